// File: rtl/door_pkg.sv
// Shared door-sequencing types and default timing constants.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package door_pkg;

  // 1 s of travel / restart hold at a 100 MHz clk.
  localparam int MOTION_TIMEOUT_DEF = 100_000_000;
  localparam int RESTART_HOLD_DEF   = 100_000_000;
  // Wide enough for the larger of the two defaults above.
  localparam int CNT_W_DEF          = 27;

  typedef enum logic [2:0] {
    CERRADA  = 3'd0,
    ABRIENDO = 3'd1,
    ABIERTA  = 3'd2,
    CERRANDO = 3'd3,
    FALLA    = 3'd4
  } door_state_t;

endpackage

// File: rtl/sync_flanco.sv
// 2-flop synchronizer followed by a rising-edge detector.
// Latency: pulso is high in the cycle after the 2nd clk edge that sees d high (acted on at the 3rd edge).
// Backpressure: none; one 1-clk pulse per rising edge of d.
// Ports: clk, restart_n (sync, active low), d (async level in), pulso (1-clk pulse out).
module sync_flanco (
  input  logic clk,
  input  logic restart_n,
  input  logic d,
  output logic pulso
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (!restart_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // s3 is the previous synchronized value; s1 may be metastable and is never used directly.
  assign pulso = s2 & ~s3;

endmodule

// File: rtl/control_puerta.sv
// Door-sequencing FSM: initiator of the door-timer handshake, drives the door motor, reports door closed.
// Latency: outputs registered, change on the edge that takes the transition; t_expired acted on 3 clk after its edge.
// Backpressure: none; level inputs sampled every clk, restart stretched to RESTART_HOLD clk for the slow timer.
// Ports: clk, restart_n (sync, active low); requests abrir_req/boton_abrir/boton_cerrar; limit switches
//   fin_abierta/fin_cerrada; blockers peso_excesivo/bloqueo_activado; t_expired from the timer;
//   outputs start_timer, restart, motor_abrir, motor_cerrar, puerta_cerrada, falla.
module control_puerta
  import door_pkg::*;
#(
  parameter int MOTION_TIMEOUT = MOTION_TIMEOUT_DEF,
  parameter int RESTART_HOLD   = RESTART_HOLD_DEF,
  parameter int CNT_W          = CNT_W_DEF
) (
  input  logic clk,
  input  logic restart_n,
  input  logic abrir_req,
  input  logic boton_abrir,
  input  logic boton_cerrar,
  input  logic fin_abierta,
  input  logic fin_cerrada,
  input  logic peso_excesivo,
  input  logic bloqueo_activado,
  input  logic t_expired,
  output logic start_timer,
  output logic restart,
  output logic motor_abrir,
  output logic motor_cerrar,
  output logic puerta_cerrada,
  output logic falla
);

  localparam logic [CNT_W-1:0] MOV_LAST = CNT_W'(MOTION_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD     = CNT_W'(RESTART_HOLD);

  door_state_t      state, state_nxt;
  logic [CNT_W-1:0] mov_cnt;
  logic [CNT_W-1:0] rst_cnt, rst_cnt_nxt;
  logic             exp_pulse, exp_ok, arm, bloqueado, mov_fin;

  sync_flanco u_sync_exp (
    .clk       (clk),
    .restart_n (restart_n),
    .d         (t_expired),
    .pulso     (exp_pulse)
  );

  assign bloqueado = peso_excesivo | bloqueo_activado;
  assign mov_fin   = (mov_cnt == MOV_LAST);
  // An expiry seen while restart is still stretched belongs to the old timer run.
  assign exp_ok    = exp_pulse & (rst_cnt == '0);

  always_comb begin
    state_nxt = state;
    arm       = 1'b0;
    case (state)
      CERRADA: begin
        if ((abrir_req | boton_abrir) && !falla) state_nxt = ABRIENDO;
      end
      ABRIENDO: begin
        // Only the switch for the current direction is consulted.
        if (fin_abierta) begin
          state_nxt = ABIERTA;
          arm       = 1'b1;
        end else if (mov_fin) begin
          state_nxt = FALLA;
        end
      end
      ABIERTA: begin
        if (bloqueado || boton_abrir) arm = 1'b1;
        else if (exp_ok || boton_cerrar) state_nxt = CERRANDO;
      end
      CERRANDO: begin
        if (bloqueado || boton_abrir) state_nxt = ABRIENDO;
        else if (fin_cerrada)         state_nxt = CERRADA;
        else if (mov_fin)             state_nxt = FALLA;
      end
      FALLA:   state_nxt = FALLA;
      default: state_nxt = FALLA;
    endcase
  end

  // Outputs decoded from the next state so they are registered and aligned with the state flop.
  always_ff @(posedge clk) begin
    if (!restart_n) begin
      state          <= CERRADA;
      start_timer    <= 1'b0;
      motor_abrir    <= 1'b0;
      motor_cerrar   <= 1'b0;
      puerta_cerrada <= 1'b1;
      falla          <= 1'b0;
    end else begin
      state          <= state_nxt;
      start_timer    <= (state_nxt == ABIERTA);
      motor_abrir    <= (state_nxt == ABRIENDO);
      motor_cerrar   <= (state_nxt == CERRANDO);
      puerta_cerrada <= (state_nxt == CERRADA);
      falla          <= (state_nxt == FALLA);
    end
  end

  // Travel counter: cleared on every state change, counts only while moving, saturates.
  always_ff @(posedge clk) begin
    if (!restart_n) begin
      mov_cnt <= '0;
    end else if (state_nxt != state) begin
      mov_cnt <= '0;
    end else if ((state == ABRIENDO || state == CERRANDO) && mov_cnt != '1) begin
      mov_cnt <= mov_cnt + CNT_W'(1);
    end
  end

  // Re-arming reloads the hold, so a held blocker keeps restart high continuously.
  always_comb begin
    if (arm)                rst_cnt_nxt = HOLD;
    else if (rst_cnt != '0) rst_cnt_nxt = rst_cnt - CNT_W'(1);
    else                    rst_cnt_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (!restart_n) begin
      rst_cnt <= '0;
      restart <= 1'b0;
    end else begin
      rst_cnt <= rst_cnt_nxt;
      restart <= (rst_cnt_nxt != '0);
    end
  end

endmodule

// File: tb/tb_control_puerta.sv
// Bench for control_puerta: directed scenarios then random inputs, checked against a behavioural model.
// Latency: model advances once per posedge, outputs compared 1 time unit later.
// Backpressure: n/a.
module tb_control_puerta;

  localparam int MT = 20;
  localparam int RH = 4;

  localparam int P_SHUT    = 0;
  localparam int P_OPENING = 1;
  localparam int P_OPEN    = 2;
  localparam int P_CLOSING = 3;
  localparam int P_FAULT   = 4;

  logic clk = 1'b0;
  logic restart_n, abrir_req, boton_abrir, boton_cerrar, fin_abierta, fin_cerrada;
  logic peso_excesivo, bloqueo_activado, t_expired;
  logic start_timer, restart, motor_abrir, motor_cerrar, puerta_cerrada, falla;

  int errors = 0;
  int checks = 0;
  int count_ma, count_mc, count_rs;

  // Model state: door position, remaining travel cycles, remaining restart cycles, t_expired history.
  int m_pos = P_SHUT;
  int m_budget = 0;
  int m_hold = 0;
  bit h1 = 0, h2 = 0, h3 = 0;

  always #5 clk = ~clk;

  control_puerta #(.MOTION_TIMEOUT(MT), .RESTART_HOLD(RH), .CNT_W(8)) dut (
    .clk              (clk),
    .restart_n        (restart_n),
    .abrir_req        (abrir_req),
    .boton_abrir      (boton_abrir),
    .boton_cerrar     (boton_cerrar),
    .fin_abierta      (fin_abierta),
    .fin_cerrada      (fin_cerrada),
    .peso_excesivo    (peso_excesivo),
    .bloqueo_activado (bloqueo_activado),
    .t_expired        (t_expired),
    .start_timer      (start_timer),
    .restart          (restart),
    .motor_abrir      (motor_abrir),
    .motor_cerrar     (motor_cerrar),
    .puerta_cerrada   (puerta_cerrada),
    .falla            (falla)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit pulse, ok, arm;
    int nxt;
    if (!restart_n) begin
      m_pos = P_SHUT; m_budget = 0; m_hold = 0;
      h1 = 0; h2 = 0; h3 = 0;
    end else begin
      // t_expired becomes actionable once it has been seen high at two edges and low at the one before.
      pulse = h2 && !h3;
      ok    = pulse && (m_hold == 0);
      arm   = 0;
      nxt   = m_pos;
      case (m_pos)
        P_SHUT:    if (abrir_req || boton_abrir) nxt = P_OPENING;
        P_OPENING: begin
          if (fin_abierta) begin nxt = P_OPEN; arm = 1; end
          else if (m_budget == 1) nxt = P_FAULT;
          else m_budget--;
        end
        P_OPEN: begin
          if (peso_excesivo || bloqueo_activado || boton_abrir) arm = 1;
          else if (ok || boton_cerrar) nxt = P_CLOSING;
        end
        P_CLOSING: begin
          if (peso_excesivo || bloqueo_activado || boton_abrir) nxt = P_OPENING;
          else if (fin_cerrada) nxt = P_SHUT;
          else if (m_budget == 1) nxt = P_FAULT;
          else m_budget--;
        end
        default: nxt = P_FAULT;
      endcase
      if (nxt != m_pos && (nxt == P_OPENING || nxt == P_CLOSING)) m_budget = MT;
      if (arm) m_hold = RH;
      else if (m_hold > 0) m_hold--;
      m_pos = nxt;
      h3 = h2; h2 = h1; h1 = t_expired;
    end
  endtask

  task automatic cycle();
    logic [5:0] obs, exp;
    @(posedge clk);
    model_step();
    #1;
    obs = {falla, puerta_cerrada, motor_cerrar, motor_abrir, restart, start_timer};
    exp = {m_pos == P_FAULT, m_pos == P_SHUT, m_pos == P_CLOSING, m_pos == P_OPENING,
           m_hold > 0, m_pos == P_OPEN};
    check("outputs{falla,cerrada,mc,ma,restart,timer}", 32'(obs), 32'(exp));
    count_ma += int'(motor_abrir);
    count_mc += int'(motor_cerrar);
    count_rs += int'(restart);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clear_counts();
    count_ma = 0; count_mc = 0; count_rs = 0;
  endtask

  initial begin
    restart_n = 0; abrir_req = 0; boton_abrir = 0; boton_cerrar = 0;
    fin_abierta = 0; fin_cerrada = 1; peso_excesivo = 0; bloqueo_activado = 0; t_expired = 0;
    clear_counts();

    // Reset state
    cycle();
    check("reset_puerta_cerrada", 32'(puerta_cerrada), 32'd1);
    check("reset_motors", 32'({motor_abrir, motor_cerrar}), 32'd0);
    check("reset_restart_timer_falla", 32'({restart, start_timer, falla}), 32'd0);

    // 1: normal cycle
    restart_n = 1; abrir_req = 1; fin_cerrada = 0; clear_counts();
    cycle();
    abrir_req = 0;
    cycles(4);
    fin_abierta = 1;
    cycle();
    check("t1_motor_abrir_cycles", 32'(count_ma), 32'd5);
    clear_counts();
    count_rs = int'(restart);
    cycles(6);
    check("t1_restart_cycles", 32'(count_rs), 32'(RH));
    check("t1_start_timer", 32'(start_timer), 32'd1);
    t_expired = 1;
    cycles(2);
    check("t1_not_closing_yet", 32'(motor_cerrar), 32'd0);
    cycle();
    check("t1_closing_3clk", 32'(motor_cerrar), 32'd1);
    fin_abierta = 0; t_expired = 0; clear_counts();
    cycles(4);
    fin_cerrada = 1;
    cycle();
    check("t1_closed", 32'(puerta_cerrada), 32'd1);
    check("t1_motor_cerrar_cycles", 32'(count_mc), 32'd4);

    // 2: obstruction while open
    boton_abrir = 1;
    cycle();
    boton_abrir = 0; fin_cerrada = 0;
    cycles(2);
    fin_abierta = 1;
    cycles(7);
    bloqueo_activado = 1; t_expired = 1; clear_counts();
    cycles(5);
    t_expired = 0;
    cycles(5);
    bloqueo_activado = 0;
    cycles(8);
    check("t2_no_close", 32'(count_mc), 32'd0);
    check("t2_still_open", 32'(start_timer), 32'd1);
    check("t2_restart_rearmed", 32'(count_rs), 32'(10 + RH - 1));
    t_expired = 1;
    cycles(3);
    check("t2_close_on_new_expiry", 32'(motor_cerrar), 32'd1);

    // 3: reopen while closing, then 4: the reopened travel times out
    fin_abierta = 0; t_expired = 0;
    cycles(2);
    peso_excesivo = 1; clear_counts();
    cycle();
    check("t3_reopen_motors", 32'({motor_abrir, motor_cerrar}), 32'b10);
    peso_excesivo = 0;
    cycles(25);
    check("t4_open_travel_cycles", 32'(count_ma), 32'(MT));
    check("t4_falla", 32'({falla, puerta_cerrada}), 32'b10);
    abrir_req = 1; clear_counts();
    cycles(5);
    check("t4_sticky_no_motion", 32'(count_ma), 32'd0);
    check("t4_sticky_falla", 32'(falla), 32'd1);
    abrir_req = 0; restart_n = 0;
    cycle();
    check("t4_reset_clears_falla", 32'({falla, puerta_cerrada}), 32'b01);
    restart_n = 1;

    // 5: close button, with both limit switches briefly high
    fin_cerrada = 1; abrir_req = 1;
    cycle();
    abrir_req = 0;
    cycle();
    check("t5_opening_ignores_fin_cerrada", 32'(motor_abrir), 32'd1);
    fin_abierta = 1;
    cycle();
    check("t5_both_switches_opened", 32'(start_timer), 32'd1);
    fin_cerrada = 0;
    cycles(6);
    boton_cerrar = 1;
    cycle();
    check("t5_close_button", 32'({motor_cerrar, start_timer}), 32'b10);
    boton_cerrar = 0;
    cycle();
    check("t5_closing_ignores_fin_abierta", 32'(motor_cerrar), 32'd1);
    fin_abierta = 0;

    // 6: reset mid-close
    cycle();
    restart_n = 0;
    cycle();
    check("t6_motors_off", 32'({motor_abrir, motor_cerrar}), 32'd0);
    check("t6_closed_no_restart", 32'({puerta_cerrada, restart}), 32'b10);
    restart_n = 1;

    // Random phase
    for (int i = 0; i < 3000; i++) begin
      restart_n        = ($urandom_range(0, 99) != 0);
      abrir_req        = ($urandom_range(0, 7) == 0);
      boton_abrir      = ($urandom_range(0, 15) == 0);
      boton_cerrar     = ($urandom_range(0, 9) == 0);
      fin_abierta      = ($urandom_range(0, 3) == 0);
      fin_cerrada      = ($urandom_range(0, 3) == 0);
      peso_excesivo    = ($urandom_range(0, 19) == 0);
      bloqueo_activado = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 5) == 0) t_expired = ~t_expired;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
